// File: rtl/sync_fifo_stream_if.sv
// sync_fifo_stream_if: write stream, read stream and status signals of sync_fifo_stream.
interface sync_fifo_stream_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 512
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [DWIDTH-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [LW-1:0]     level;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, level, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, level, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_stream.sv
// sync_fifo_stream: single-clock valid/ready FIFO, registered-read RAM feeding a 2-entry output stage.
// Define SYNC_FIFO_STREAM_ERR_EN for sticky overflow/underflow flags.
module sync_fifo_stream #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 512,
  parameter     RAM_STYLE = "auto",
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input logic clk,
  input logic rst,
  sync_fifo_stream_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] AF = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE = LW'(AE_THRESH);
  (* ram_style = RAM_STYLE *) logic [DWIDTH-1:0] mem [DEPTH];
  logic [LW-1:0] wptr, rptr, lvl, lvl_nxt;
  logic [DWIDTH-1:0] rd_q, ob0, ob1;
  logic [1:0] oc, oc_pop;
  logic pend, rdy, af, ae, push, pop, rd_en;
  // Prefetch whenever the output stage plus the in-flight read leaves a free slot.
  always_comb begin
    push = f.s_valid & rdy;
    pop = (oc != 2'd0) & f.m_ready;
    oc_pop = oc - {1'b0, pop};
    rd_en = (wptr != rptr) & (({1'b0, oc} + {2'b0, pend}) < ({2'b0, pop} + 3'd2));
    lvl_nxt = lvl + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      oc <= 2'd0;
      pend <= 1'b0;
      lvl <= '0;
      rdy <= 1'b0;
      af <= 1'b0;
      ae <= 1'b1;
    end else begin
      wptr <= wptr + LW'(push);
      rptr <= rptr + LW'(rd_en);
      pend <= rd_en;
      oc <= oc_pop + {1'b0, pend};
      lvl <= lvl_nxt;
      rdy <= lvl_nxt < FULL;
      af <= lvl_nxt >= AF;
      ae <= lvl_nxt <= AE;
    end
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= f.s_data;
    if (rd_en) rd_q <= mem[rptr[AW-1:0]];
    if (pop & oc[1]) ob0 <= ob1;
    else if (pend & (oc_pop == 2'd0)) ob0 <= rd_q;
    if (pend & (oc_pop == 2'd1)) ob1 <= rd_q;
  end
  assign f.s_ready = rdy;
  assign f.m_data = ob0;
  assign f.m_valid = oc != 2'd0;
  assign f.level = lvl;
  assign f.almost_full = af;
  assign f.almost_empty = ae;
`ifdef SYNC_FIFO_STREAM_ERR_EN
  logic ovf, unf, seen;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
      seen <= 1'b0;
    end else begin
      ovf <= ovf | (f.s_valid & ~rdy);
      unf <= unf | (seen & f.m_ready & (oc == 2'd0));
      seen <= seen | (oc != 2'd0);
    end
  assign f.overflow = ovf;
  assign f.underflow = unf;
`else
  assign f.overflow = 1'b0;
  assign f.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_stream.sv
// tb_sync_fifo_stream: directed vector table plus fill/drain, streaming, random and reset sequences.
module tb_sync_fifo_stream;
  localparam int DW = 16;
  localparam int DP = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  sync_fifo_stream_if #(.DWIDTH(DW), .DEPTH(DP)) f();
  sync_fifo_stream #(.DWIDTH(DW), .DEPTH(DP), .AF_THRESH(12), .AE_THRESH(4)) dut (
    .clk(clk),
    .rst(rst),
    .f(f)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        sv;
    logic [15:0] d;
    logic        mr;
    logic        mv;
    logic [15:0] md;
    int          lvl;
  } vec_t;
  vec_t vt [12];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic flags(input string n, input int l);
    chk({n, "_level"}, 32'(f.level), l);
    chk({n, "_s_ready"}, 32'(f.s_ready), 32'(l < DP));
    chk({n, "_af"}, 32'(f.almost_full), 32'(l >= 12));
    chk({n, "_ae"}, 32'(f.almost_empty), 32'(l <= 4));
  endtask
  initial begin
    logic p, q;
    logic [15:0] exp;
    logic [15:0] sb [$];
    int k, el, sent, got, pushed, l0;
    vt[0]  = '{1'b1, 16'h00A5, 1'b0, 1'b0, 16'h0000, 1};
    vt[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1};
    vt[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h00A5, 1};
    vt[3]  = '{1'b1, 16'h0011, 1'b1, 1'b0, 16'h0000, 1};
    vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1};
    vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0011, 1};
    vt[6]  = '{1'b1, 16'h0022, 1'b0, 1'b1, 16'h0011, 2};
    vt[7]  = '{1'b1, 16'h0033, 1'b0, 1'b1, 16'h0011, 3};
    vt[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0022, 2};
    vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0033, 1};
    vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0};
    vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0};
    f.s_valid = 1'b0;
    f.s_data = '0;
    f.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(f.s_ready), 0);
    chk("rst_m_valid", 32'(f.m_valid), 0);
    chk("rst_level", 32'(f.level), 0);
    chk("rst_af", 32'(f.almost_full), 0);
    chk("rst_ae", 32'(f.almost_empty), 1);
    chk("rst_ovf", 32'(f.overflow), 0);
    chk("rst_unf", 32'(f.underflow), 0);
    rst = 1'b0;
    step();
    flags("idle", 0);
    chk("idle_m_valid", 32'(f.m_valid), 0);
    for (int i = 0; i < 12; i++) begin
      f.s_valid = vt[i].sv;
      f.s_data = vt[i].d;
      f.m_ready = vt[i].mr;
      step();
      chk($sformatf("v%0d_m_valid", i), 32'(f.m_valid), 32'(vt[i].mv));
      if (vt[i].mv) chk($sformatf("v%0d_m_data", i), 32'(f.m_data), 32'(vt[i].md));
      chk($sformatf("v%0d_level", i), 32'(f.level), vt[i].lvl);
      chk($sformatf("v%0d_s_ready", i), 32'(f.s_ready), 1);
    end
    f.m_ready = 1'b0;
    f.s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f.s_data = 16'h0040 + 16'(i);
      step();
      flags($sformatf("fill%0d", i), i + 1);
    end
    f.s_data = 16'hFFFF;
    step();
    flags("over", 16);
`ifdef SYNC_FIFO_STREAM_ERR_EN
    chk("overflow", 32'(f.overflow), 1);
`else
    chk("overflow", 32'(f.overflow), 0);
`endif
    f.s_valid = 1'b0;
    f.m_ready = 1'b1;
    k = 0;
    el = 16;
    for (int c = 0; c < 80 && k < 16; c++) begin
      if (f.m_valid) begin
        chk($sformatf("drain%0d_data", k), 32'(f.m_data), 32'(16'h0040 + 16'(k)));
        k++;
        el--;
      end
      step();
      flags("drain", el);
    end
    chk("drain_cnt", k, 16);
    step();
`ifdef SYNC_FIFO_STREAM_ERR_EN
    chk("underflow", 32'(f.underflow), 1);
`else
    chk("underflow", 32'(f.underflow), 0);
`endif
    sent = 0;
    got = 0;
    for (int c = 0; c < 1200 && got < 1024; c++) begin
      f.s_valid = sent < 1024;
      f.s_data = 16'(sent);
      p = f.s_valid & f.s_ready;
      q = f.m_valid;
      l0 = int'(f.level);
      if (got > 0 && got < 1024) chk("stream_bubble", 32'(f.m_valid), 1);
      if (q) begin
        chk("stream_data", 32'(f.m_data), 32'(16'(got)));
        got++;
      end
      step();
      if (p & q) chk("stream_level", 32'(f.level), l0);
      sent += int'(p);
    end
    chk("stream_cnt", got, 1024);
    f.s_valid = 1'b0;
    step();
    flags("stream_end", 0);
    pushed = 0;
    for (int c = 0; c < 20000 && pushed < 3000; c++) begin
      f.s_valid = 1'($urandom_range(0, 1));
      f.s_data = 16'($urandom);
      f.m_ready = 1'($urandom_range(0, 1));
      p = f.s_valid & f.s_ready;
      q = f.m_valid & f.m_ready;
      if (q) begin
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = 16'hxxxx;
        chk("rnd_data", 32'(f.m_data), 32'(exp));
      end
      if (p) sb.push_back(f.s_data);
      pushed += int'(p);
      step();
      flags("rnd", sb.size());
    end
    chk("rnd_cnt", pushed, 3000);
    f.s_valid = 1'b0;
    f.m_ready = 1'b1;
    for (int c = 0; c < 40 && f.level != 0; c++) step();
    flags("rnd_drained", 0);
    f.m_ready = 1'b0;
    f.s_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      f.s_data = 16'h0100 + 16'(i);
      step();
    end
    f.s_valid = 1'b0;
    step();
    flags("pre_rst", 7);
    chk("pre_rst_m_valid", 32'(f.m_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 32'(f.m_valid), 0);
    chk("mid_rst_level", 32'(f.level), 0);
    chk("mid_rst_s_ready", 32'(f.s_ready), 0);
    chk("mid_rst_ae", 32'(f.almost_empty), 1);
    chk("mid_rst_af", 32'(f.almost_full), 0);
    #2 rst = 1'b0;
    step();
    f.s_valid = 1'b1;
    f.s_data = 16'h0077;
    step();
    f.s_valid = 1'b0;
    f.m_ready = 1'b1;
    for (int c = 0; c < 10 && !f.m_valid; c++) step();
    chk("post_rst_m_valid", 32'(f.m_valid), 1);
    chk("post_rst_data", 32'(f.m_data), 32'h77);
    chk("post_rst_level", 32'(f.level), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
